// File: rtl/axis_out_packer_if.sv
// AXI4-Stream master bundle for the output packer: data, byte keep/strobe, last.
// The packer drives the master side; the downstream consumer owns TREADY.
interface axis_out_packer_if #(
  parameter int DATA_W = 32
);
  logic                  M_AXIS_TREADY;
  logic                  M_AXIS_TVALID;
  logic [DATA_W-1:0]     M_AXIS_TDATA;
  logic [DATA_W/8-1:0]   M_AXIS_TKEEP;
  logic [DATA_W/8-1:0]   M_AXIS_TSTRB;
  logic                  M_AXIS_TLAST;

  modport master (
    input  M_AXIS_TREADY,
    output M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TKEEP, M_AXIS_TSTRB, M_AXIS_TLAST
  );

  modport slave (
    output M_AXIS_TREADY,
    input  M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TKEEP, M_AXIS_TSTRB, M_AXIS_TLAST
  );
endinterface

// File: rtl/axis_out_packer.sv
// Packs IN_WIDTH-bit beats LSB-first into words, queues them and streams them out; first word valid 1 cycle after its push.
// TREADY low fills the FIFO, then in_ready drops; beats offered while not ready are dropped and flag overflow_err.
module axis_out_packer #(
  parameter int IN_WIDTH             = 1,
  parameter int C_M_AXIS_TDATA_WIDTH = 32,
  parameter int FIFO_DEPTH           = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                layer_finish,
  input  logic                in_valid,
  input  logic [IN_WIDTH-1:0] in_data,
  output logic                in_ready,
  output logic                overflow_err,
  axis_out_packer_if.master   m_axis
);
  localparam int W     = C_M_AXIS_TDATA_WIDTH;
  localparam int KW    = W / 8;
  localparam int BPW   = W / IN_WIDTH;
  localparam int PTR_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BPW - 1);

  typedef enum logic [0:0] {RUN, FLUSH_PEND} state_t;

  state_t           r_state, w_state_nxt;
  logic [W-1:0]     r_acc, w_acc_nxt, w_acc_merged;
  logic [PTR_W-1:0] r_ptr, w_ptr_nxt;
  logic             r_dirty, w_dirty_nxt;
  logic             r_ovf;

  logic [W-1:0]     r_fifo_dat  [FIFO_DEPTH];
  logic [KW-1:0]    r_fifo_keep [FIFO_DEPTH];
  logic             r_fifo_last [FIFO_DEPTH];
  logic [AW:0]      r_wr_ptr, r_rd_ptr;

  logic             w_fifo_empty, w_fifo_full, w_pop;
  logic             w_accept, w_complete, w_has_data;
  int               w_fill_bits;
  logic [KW-1:0]    w_part_keep;
  logic             w_push, w_push_last;
  logic [W-1:0]     w_push_dat;
  logic [KW-1:0]    w_push_keep;

  assign w_fifo_empty = (r_wr_ptr == r_rd_ptr);
  assign w_fifo_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                        (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop        = !w_fifo_empty && m_axis.M_AXIS_TREADY;

  assign in_ready     = (r_state == RUN) && !w_fifo_full;
  assign overflow_err = r_ovf;
  assign w_accept     = in_valid && in_ready;
  assign w_complete   = w_accept && (r_ptr == LAST_PTR);

  // Head is gated by empty so stale or uninitialised entries never reach the bus.
  assign m_axis.M_AXIS_TVALID = !w_fifo_empty;
  assign m_axis.M_AXIS_TDATA  = w_fifo_empty ? '0 : r_fifo_dat[r_rd_ptr[AW-1:0]];
  assign m_axis.M_AXIS_TKEEP  = w_fifo_empty ? '0 : r_fifo_keep[r_rd_ptr[AW-1:0]];
  assign m_axis.M_AXIS_TSTRB  = m_axis.M_AXIS_TKEEP;
  assign m_axis.M_AXIS_TLAST  = w_fifo_empty ? 1'b0 : r_fifo_last[r_rd_ptr[AW-1:0]];

  always_comb begin
    w_acc_merged = r_acc;
    if (w_accept) begin
      w_acc_merged[r_ptr*IN_WIDTH +: IN_WIDTH] = in_data;
    end
    w_fill_bits = (int'(r_ptr) + (w_accept ? 1 : 0)) * IN_WIDTH;
    w_has_data  = (w_fill_bits != 0);
    w_part_keep = '0;
    for (int b = 0; b < KW; b++) begin
      w_part_keep[b] = ((b * 8) < w_fill_bits);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_ptr_nxt   = r_ptr;
    w_dirty_nxt = r_dirty;
    w_push      = 1'b0;
    w_push_dat  = '0;
    w_push_keep = '0;
    w_push_last = 1'b0;
    case (r_state)
      RUN: begin
        if (w_accept) begin
          w_acc_nxt = w_acc_merged;
          w_ptr_nxt = r_ptr + 1'b1;
        end
        if (w_complete) begin
          w_push      = 1'b1;
          w_push_dat  = w_acc_merged;
          w_push_keep = '1;
          w_push_last = layer_finish;
          w_acc_nxt   = '0;
          w_ptr_nxt   = '0;
        end else if (layer_finish && (w_has_data || r_dirty)) begin
          if (!w_fifo_full) begin
            w_push      = 1'b1;
            w_push_dat  = w_acc_merged;
            w_push_keep = w_part_keep;
            w_push_last = 1'b1;
            w_acc_nxt   = '0;
            w_ptr_nxt   = '0;
          end else begin
            w_state_nxt = FLUSH_PEND;
          end
        end
      end
      FLUSH_PEND: begin
        // No beats are accepted here, so acc/ptr still describe the pending flush.
        if (!w_fifo_full) begin
          w_push      = 1'b1;
          w_push_dat  = r_acc;
          w_push_keep = w_part_keep;
          w_push_last = 1'b1;
          w_acc_nxt   = '0;
          w_ptr_nxt   = '0;
          w_state_nxt = RUN;
        end
      end
      default: w_state_nxt = RUN;
    endcase
    if (w_push) begin
      w_dirty_nxt = !w_push_last;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= RUN;
      r_acc    <= '0;
      r_ptr    <= '0;
      r_dirty  <= 1'b0;
      r_ovf    <= 1'b0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_ptr   <= w_ptr_nxt;
      r_dirty <= w_dirty_nxt;
      if (in_valid && !in_ready) begin
        r_ovf <= 1'b1;
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_dat[r_wr_ptr[AW-1:0]]  <= w_push_dat;
      r_fifo_keep[r_wr_ptr[AW-1:0]] <= w_push_keep;
      r_fifo_last[r_wr_ptr[AW-1:0]] <= w_push_last;
    end
  end
endmodule

// File: tb/tb_axis_out_packer.sv
// Two packers (1-bit and 8-bit beats) driven from directed tables and a random run;
// expected words are queued on stimulus and popped on each output handshake.
module tb_axis_out_packer;
  typedef struct packed {
    logic [31:0] dat;
    logic [3:0]  keep;
    logic        last;
  } word_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       lf1, iv1, id1, ir1, ovf1;
  logic       lf8, iv8, ir8, ovf8;
  logic [7:0] id8;

  axis_out_packer_if #(.DATA_W(32)) if1 ();
  axis_out_packer_if #(.DATA_W(32)) if8 ();

  axis_out_packer #(.IN_WIDTH(1), .C_M_AXIS_TDATA_WIDTH(32), .FIFO_DEPTH(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .layer_finish(lf1), .in_valid(iv1), .in_data(id1),
    .in_ready(ir1), .overflow_err(ovf1), .m_axis(if1)
  );

  axis_out_packer #(.IN_WIDTH(8), .C_M_AXIS_TDATA_WIDTH(32), .FIFO_DEPTH(4)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .layer_finish(lf8), .in_valid(iv8), .in_data(id8),
    .in_ready(ir8), .overflow_err(ovf8), .m_axis(if8)
  );

  int    n_total = 0;
  int    n_bad   = 0;
  word_t q1[$];
  word_t q8[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    word_t e;
    if (rst_n && if1.M_AXIS_TVALID && if1.M_AXIS_TREADY) begin
      if (q1.size() == 0) begin
        check("extra_word1", 1, 0);
      end else begin
        e = q1.pop_front();
        check("dat1", if1.M_AXIS_TDATA, e.dat);
        check("keep1", if1.M_AXIS_TKEEP, e.keep);
        check("last1", if1.M_AXIS_TLAST, e.last);
      end
    end
  end

  logic  p8_vld = 1'b0;
  logic  p8_rdy = 1'b0;
  word_t p8_w;
  always @(negedge clk) begin
    word_t e;
    if (rst_n) begin
      if (p8_vld && !p8_rdy) begin
        check("stall_vld8", if8.M_AXIS_TVALID, 1);
        check("stall_word8", {if8.M_AXIS_TDATA, if8.M_AXIS_TKEEP, if8.M_AXIS_TLAST}, p8_w);
      end
      if (if8.M_AXIS_TVALID && if8.M_AXIS_TREADY) begin
        if (q8.size() == 0) begin
          check("extra_word8", 1, 0);
        end else begin
          e = q8.pop_front();
          check("dat8", if8.M_AXIS_TDATA, e.dat);
          check("keep8", if8.M_AXIS_TKEEP, e.keep);
          check("strb8", if8.M_AXIS_TSTRB, e.keep);
          check("last8", if8.M_AXIS_TLAST, e.last);
        end
      end
    end
    p8_vld = rst_n && if8.M_AXIS_TVALID;
    p8_rdy = if8.M_AXIS_TREADY;
    p8_w   = {if8.M_AXIS_TDATA, if8.M_AXIS_TKEEP, if8.M_AXIS_TLAST};
  end

  task automatic step1(input logic v, input logic d, input logic lf);
    iv1 = v; id1 = d; lf1 = lf;
    @(posedge clk); #1;
    iv1 = 1'b0; id1 = 1'b0; lf1 = 1'b0;
  endtask

  task automatic step8(input logic v, input logic [7:0] d, input logic lf);
    iv8 = v; id8 = d; lf8 = lf;
    @(posedge clk); #1;
    iv8 = 1'b0; id8 = 8'h00; lf8 = 1'b0;
  endtask

  task automatic drain1();
    for (int i = 0; i < 200 && q1.size() != 0; i++) @(posedge clk);
    #1;
    check("drain1", q1.size(), 0);
  endtask

  task automatic drain8();
    for (int i = 0; i < 400 && q8.size() != 0; i++) @(posedge clk);
    #1;
    check("drain8", q8.size(), 0);
  endtask

  // Reference packer for the 8-bit instance in the random run.
  logic [31:0] m_acc   = '0;
  int          m_nb    = 0;
  logic        m_dirty = 1'b0;
  task automatic model8(input logic a, input logic [7:0] b, input logic lf);
    logic [3:0] k;
    if (a) begin
      m_acc[m_nb*8 +: 8] = b;
      m_nb++;
    end
    if (a && m_nb == 4) begin
      q8.push_back(word_t'{m_acc, 4'hF, lf});
      m_dirty = !lf;
      m_acc = '0;
      m_nb = 0;
    end else if (lf) begin
      if (m_nb != 0) begin
        k = 4'((1 << m_nb) - 1);
        q8.push_back(word_t'{m_acc, k, 1'b1});
        m_acc = '0;
        m_nb = 0;
        m_dirty = 1'b0;
      end else if (m_dirty) begin
        q8.push_back(word_t'{32'h0, 4'h0, 1'b1});
        m_dirty = 1'b0;
      end
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  logic [31:0] t1w [3];
  logic [31:0] wacc;
  int          n_acc;
  int          cyc;
  logic        v, lf, a;
  logic [7:0]  b;

  initial begin
    t1w[0] = 32'h12345678; t1w[1] = 32'h9ABCDEF0; t1w[2] = 32'h98765432;
    rst_n = 1'b0;
    lf1 = 1'b0; iv1 = 1'b0; id1 = 1'b0;
    lf8 = 1'b0; iv8 = 1'b0; id8 = 8'h00;
    if1.M_AXIS_TREADY = 1'b0;
    if8.M_AXIS_TREADY = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("rst_tvalid", if8.M_AXIS_TVALID, 0);
    check("rst_tdata", if8.M_AXIS_TDATA, 0);
    check("rst_tkeep", if8.M_AXIS_TKEEP, 0);
    check("rst_tstrb", if8.M_AXIS_TSTRB, 0);
    check("rst_tlast", if8.M_AXIS_TLAST, 0);
    check("rst_in_ready8", ir8, 1);
    check("rst_in_ready1", ir1, 1);
    check("rst_ovf8", ovf8, 0);
    check("rst_ovf1", ovf1, 0);
    @(posedge clk); #1;

    // 1-bit beats: three full words, one trailing bit, then flush
    if1.M_AXIS_TREADY = 1'b1;
    for (int w = 0; w < 3; w++) begin
      q1.push_back(word_t'{t1w[w], 4'hF, 1'b0});
      for (int i = 0; i < 32; i++) step1(1'b1, t1w[w][i], 1'b0);
    end
    q1.push_back(word_t'{32'h1, 4'h1, 1'b1});
    step1(1'b1, 1'b1, 1'b0);
    step1(1'b0, 1'b0, 1'b1);
    drain1();

    // Exact word, flush next cycle gives a null word; second flush is silent
    q1.push_back(word_t'{32'hFFFFFFFF, 4'hF, 1'b0});
    q1.push_back(word_t'{32'h0, 4'h0, 1'b1});
    for (int i = 0; i < 32; i++) step1(1'b1, 1'b1, 1'b0);
    step1(1'b0, 1'b0, 1'b1);
    step1(1'b0, 1'b0, 1'b1);
    repeat (6) step1(1'b0, 1'b0, 1'b0);
    drain1();

    // 8-bit beats: partial word closed by a flush in the same cycle as the last beat
    if8.M_AXIS_TREADY = 1'b1;
    q8.push_back(word_t'{32'h00CCBBAA, 4'h7, 1'b1});
    step8(1'b1, 8'hAA, 1'b0);
    step8(1'b1, 8'hBB, 1'b0);
    step8(1'b1, 8'hCC, 1'b1);
    check("latency8", if8.M_AXIS_TVALID, 1);
    drain8();

    // Stalled output: fill FIFO, overflow, deferred flush, then release
    if8.M_AXIS_TREADY = 1'b0;
    wacc = '0;
    for (int i = 0; i < 16; i++) begin
      wacc[(i % 4)*8 +: 8] = 8'(8'h10 + i);
      if (i % 4 == 3) q8.push_back(word_t'{wacc, 4'hF, 1'b0});
      step8(1'b1, 8'(8'h10 + i), 1'b0);
    end
    check("full_in_ready8", ir8, 0);
    step8(1'b1, 8'hEE, 1'b0);
    check("overflow8", ovf8, 1);
    q8.push_back(word_t'{32'h0, 4'h0, 1'b1});
    step8(1'b0, 8'h00, 1'b1);
    check("pend_in_ready8", ir8, 0);
    repeat (3) step8(1'b0, 8'h00, 1'b0);
    step8(1'b0, 8'h00, 1'b1);
    repeat (2) step8(1'b0, 8'h00, 1'b0);
    if8.M_AXIS_TREADY = 1'b1;
    drain8();
    check("pend_exit_in_ready8", ir8, 1);
    check("overflow_sticky8", ovf8, 1);

    // Asynchronous reset with a queued word and a half-built word
    if8.M_AXIS_TREADY = 1'b0;
    for (int i = 0; i < 6; i++) step8(1'b1, 8'(8'h50 + i), 1'b0);
    check("pre_rst_tvalid8", if8.M_AXIS_TVALID, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_tvalid8", if8.M_AXIS_TVALID, 0);
    check("async_rst_ovf8", ovf8, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready8", ir8, 1);
    if8.M_AXIS_TREADY = 1'b1;
    q8.push_back(word_t'{32'h04030201, 4'hF, 1'b1});
    step8(1'b1, 8'h01, 1'b0);
    step8(1'b1, 8'h02, 1'b0);
    step8(1'b1, 8'h03, 1'b0);
    step8(1'b1, 8'h04, 1'b1);
    drain8();

    // Random valid/ready with occasional flushes
    n_acc = 0;
    cyc = 0;
    while (n_acc < 1000 && cyc < 20000) begin
      if8.M_AXIS_TREADY = ($urandom_range(0, 3) != 0);
      v  = ($urandom_range(0, 3) != 0);
      b  = 8'($urandom);
      lf = ir8 && ($urandom_range(0, 24) == 0);
      a  = v && ir8;
      model8(a, b, lf);
      step8(v, b, lf);
      if (a) n_acc++;
      cyc++;
    end
    check("rand_beats", n_acc, 1000);
    if8.M_AXIS_TREADY = 1'b1;
    drain8();
    model8(1'b0, 8'h00, 1'b1);
    step8(1'b0, 8'h00, 1'b1);
    drain8();
    repeat (4) @(posedge clk);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
